// File: rtl/carry_lookahead_adder_4b.sv
`default_nettype none
// ============================================================================
//  Module   : carry_lookahead_adder_4b
//  Purpose  : 4-bit carry-lookahead adder with registered outputs.
//             Computes A+B+Cin through a single level of expanded lookahead
//             logic, so no carry depends on another carry. Sum, carry out and
//             the group propagate/generate terms are registered, which lets
//             wider hierarchical CLA adders consume PG/GG directly.
//  Ports    : clk  - clock, all state updates on its rising edge
//             rst  - asynchronous active-high reset, clears all outputs
//             A    - 4-bit unsigned addend
//             B    - 4-bit unsigned addend
//             Cin  - carry into bit 0
//             Sum  - registered (A+B+Cin) mod 16
//             Cout - registered carry out of bit 3
//             PG   - registered group propagate (p3&p2&p1&p0)
//             GG   - registered group generate (carry out assuming Cin=0)
//  Latency  : 1 clock, one operand set accepted per cycle
//  Revision : 1.0  initial release
// ============================================================================
module carry_lookahead_adder_4b (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       PG,
  output logic       GG
);

  // Per-bit propagate and generate terms.
  logic [3:0] p;
  logic [3:0] g;

  // Carries into each bit position plus the carry out of bit 3.
  logic [4:0] c;

  logic [3:0] sum_next;
  logic       pg_next;
  logic       gg_next;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is written in fully expanded two-level form directly from
  // p, g and Cin; none references a lower carry, so there is no ripple path.
  assign c[0] = Cin;
  assign c[1] = g[0]
              | (p[0] & Cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & Cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign sum_next = p ^ c[3:0];

  // Group terms exclude Cin so a higher lookahead level can combine them.
  assign pg_next = &p;
  assign gg_next = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

  // Asynchronous clear: outputs drop to zero as soon as rst rises, and any
  // result in flight is discarded rather than replayed after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum  <= 4'b0000;
      Cout <= 1'b0;
      PG   <= 1'b0;
      GG   <= 1'b0;
    end else begin
      Sum  <= sum_next;
      Cout <= c[4];
      PG   <= pg_next;
      GG   <= gg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_carry_lookahead_adder_4b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_carry_lookahead_adder_4b
//  Purpose  : Self-checking bench for carry_lookahead_adder_4b. An arithmetic
//             reference model is compared against the DUT after every rising
//             edge; directed vectors with literal expectations pin the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_carry_lookahead_adder_4b;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       PG;
  logic       GG;

  int checks = 0;
  int errors = 0;

  carry_lookahead_adder_4b dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout),
    .PG   (PG),
    .GG   (GG)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {PG, GG, Cout, Sum[3:0]} from plain integer arithmetic.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
    int  total;
    int  no_cin;
    logic pg;
    logic gg;
    total  = int'(a) + int'(b) + int'(cin);
    no_cin = int'(a) + int'(b);
    pg     = ((a ^ b) == 4'hF);
    gg     = (no_cin > 15);
    return {pg, gg, total[4:0]};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {PG,GG,Cout,Sum}=%b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model one edge after sampling.
  always @(posedge clk) begin
    logic [6:0] exp;
    if (rst) exp = 7'b0;
    else     exp = model(A, B, Cin);
    #1;
    check("model", {PG, GG, Cout, Sum}, exp);
  end

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [6:0] exp, input string name);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    @(posedge clk);
    #2;
    check(name, {PG, GG, Cout, Sum}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    A   = 4'd0;
    B   = 4'd0;
    Cin = 1'b0;
    #2;
    check("reset_initial", {PG, GG, Cout, Sum}, 7'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, expectations written as {PG,GG,Cout,Sum}.
    apply(4'b0000, 4'b0000, 1'b0, 7'b0_0_0_0000, "zero");
    apply(4'b0001, 4'b0010, 1'b0, 7'b0_0_0_0011, "small");
    apply(4'b1010, 4'b0101, 1'b1, 7'b1_0_1_0000, "full_propagate");
    apply(4'b1111, 4'b0001, 1'b0, 7'b0_1_1_0000, "carry_through");
    apply(4'b0111, 4'b1000, 1'b0, 7'b1_0_0_1111, "propagate_no_cin");
    apply(4'b1001, 4'b0110, 1'b1, 7'b1_0_1_0000, "propagate_cin");
    apply(4'b0101, 4'b0011, 1'b0, 7'b0_0_0_1000, "mid_carry");
    apply(4'b1111, 4'b1111, 1'b1, 7'b0_1_1_1111, "max");

    // Asynchronous reset between edges while Sum is nonzero.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", {PG, GG, Cout, Sum}, 7'b0);

    // Release with new inputs: nothing reappears until the next edge.
    @(negedge clk);
    rst = 1'b0;
    A   = 4'd3;
    B   = 4'd4;
    Cin = 1'b1;
    #1;
    check("reset_hold_after_release", {PG, GG, Cout, Sum}, 7'b0);
    @(posedge clk);
    #2;
    check("reset_release_load", {PG, GG, Cout, Sum}, 7'b0_0_0_1000);

    // Exhaustive back-to-back sweep; the compare process checks each result.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      @(negedge clk);
      A   = v[8:5];
      B   = v[4:1];
      Cin = v[0];
    end
    @(posedge clk);
    #2;
    check("sweep_last", {PG, GG, Cout, Sum}, 7'b0_1_1_1111);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
